dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/lc3b_types.sv | 13 +
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b data types used by the data-memory responder and its storage array.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lc3b_memresp_state;

endpackage

// File: rtl/dmem_array.sv
// Byte-writable word storage: one asynchronous read port, one synchronous write port.
// Contents are deliberately not reset so data survives a responder reset.
module dmem_array
    import lc3b_types::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  lc3b_mem_wmask         byte_en,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  lc3b_word              wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output lc3b_word              rdata
);

    lc3b_word mem_r [2**DEPTH_LOG2];

    // Byte-lane write; each enabled lane is updated independently
    always_ff @(posedge clk) begin
        if (we) begin
            if (byte_en[0]) begin
                mem_r[waddr][7:0] <= wdata[7:0];
            end
            if (byte_en[1]) begin
                mem_r[waddr][15:8] <= wdata[15:8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency LC-3b data-memory responder: captures a request, waits LATENCY cycles,
// then pulses mem_resp with read data or commits the byte-masked write.
module dmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [15:0]   mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          protocol_err
);

    localparam logic [3:0] LOAD_VAL = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    lc3b_memresp_state     state_r, state_next_s;
    logic [3:0]            count_r, count_next_s;
    logic [DEPTH_LOG2-1:0] idx_r;
    lc3b_word              wdata_r;
    lc3b_mem_wmask         be_r;
    logic                  op_write_r;
    logic                  mem_resp_r;
    lc3b_word              mem_rdata_r;
    logic                  protocol_err_r;

    logic                  req_s;
    logic                  capture_s;
    logic                  is_write_s;
    logic [DEPTH_LOG2-1:0] rd_idx_s;
    lc3b_word              rd_data_s;
    logic                  we_s;
    logic                  unused_addr_s;

    assign req_s     = mem_read | mem_write;
    assign capture_s = (state_r == IDLE) && req_s;

    // With LATENCY=1 the RESP entry coincides with capture, so look at live inputs in IDLE
    assign is_write_s = (state_r == IDLE) ? mem_write : op_write_r;
    assign rd_idx_s   = (state_r == IDLE) ? mem_address[DEPTH_LOG2:1] : idx_r;

    // Commit on the edge that ends RESP; a reset on that edge cancels it
    assign we_s = (state_r == RESP) && op_write_r && !reset;

    assign unused_addr_s = ^mem_address;

    // Next-state and countdown logic
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    count_next_s = LOAD_VAL;
                    state_next_s = (LATENCY >= 2) ? WAIT : RESP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    state_next_s = IDLE;
                end else if (count_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    count_next_s = count_r - 4'd1;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                count_next_s = 4'd0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            count_r        <= 4'd0;
            mem_resp_r     <= 1'b0;
            mem_rdata_r    <= 16'h0000;
            protocol_err_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            count_r        <= count_next_s;
            mem_resp_r     <= (state_next_s == RESP);
            mem_rdata_r    <= ((state_next_s == RESP) && !is_write_s) ? rd_data_s : 16'h0000;
            protocol_err_r <= capture_s && mem_read && mem_write;
        end
    end

    // Transaction capture; the initiator may change inputs freely afterwards
    always_ff @(posedge clk) begin
        if (capture_s) begin
            idx_r      <= mem_address[DEPTH_LOG2:1];
            wdata_r    <= mem_wdata;
            be_r       <= mem_byte_enable;
            op_write_r <= mem_write;
        end
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we      (we_s),
        .byte_en (be_r),
        .waddr   (idx_r),
        .wdata   (wdata_r),
        .raddr   (rd_idx_s),
        .rdata   (rd_data_s)
    );

    assign mem_resp     = mem_resp_r;
    assign mem_rdata    = mem_rdata_r;
    assign protocol_err = protocol_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a LATENCY=2 instance for function
// tests and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [15:0] mem_address, mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp, protocol_err;
    logic [15:0] mem_rdata;

    logic        b_read, b_write;
    logic [15:0] b_address, b_wdata;
    logic [1:0]  b_be;
    logic        b_resp, b_err;
    logic [15:0] b_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(2), .DEPTH_LOG2(8)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .protocol_err(protocol_err)
    );

    dmem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut_l1 (
        .clk(clk), .reset(reset), .mem_read(b_read), .mem_write(b_write),
        .mem_address(b_address), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
        .mem_resp(b_resp), .mem_rdata(b_rdata), .protocol_err(b_err)
    );

    // Drives one transaction on the LATENCY=2 instance and reports what it observed
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be,
                           output int lat, output logic [15:0] rdata, output int err_pulses,
                           output logic post_resp, output logic [15:0] post_rdata);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
        lat = -1; err_pulses = 0; rdata = 16'h0000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (protocol_err) err_pulses++;
            if (mem_resp) begin
                lat = c; rdata = mem_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        post_resp = mem_resp; post_rdata = mem_rdata;
        if (protocol_err) err_pulses++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0", mem_resp); end
        checks++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", mem_rdata); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", protocol_err); end
    endtask

    task automatic test_req_through_reset();
        int lat = -1;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 16'h0040;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_resp) begin lat = c; break; end
        end
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        checks++; if (lat !== 2) begin errors++; $display("FAIL held_req_lat: got %0d expected 2", lat); end
    endtask

    task automatic test_write_read();
        int lat, ep; logic [15:0] rd, prd; logic pr;
        run_txn(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, lat, rd, ep, pr, prd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d expected 2", lat); end
        checks++; if (pr !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: got %b expected 0", pr); end
        run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat: got %0d expected 2", lat); end
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h expected 1234", rd); end
        checks++; if (pr !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %b expected 0", pr); end
        checks++; if (prd !== 16'h0000) begin errors++; $display("FAIL rd_data_idle: got %h expected 0000", prd); end
        checks++; if (ep !== 0) begin errors++; $display("FAIL rd_no_err: got %0d expected 0", ep); end
    endtask

    task automatic test_byte_write();
        int lat, ep; logic [15:0] rd, prd; logic pr;
        run_txn(1'b0, 1'b1, 16'h0020, 16'hAAAA, 2'b11, lat, rd, ep, pr, prd);
        run_txn(1'b0, 1'b1, 16'h0020, 16'h5511, 2'b01, lat, rd, ep, pr, prd);
        run_txn(1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'hAA11) begin errors++; $display("FAIL be01_data: got %h expected aa11", rd); end
        run_txn(1'b0, 1'b1, 16'h0020, 16'h7799, 2'b10, lat, rd, ep, pr, prd);
        run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'h7711) begin errors++; $display("FAIL be10_data: got %h expected 7711", rd); end
        run_txn(1'b0, 1'b1, 16'h0020, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL be00_lat: got %0d expected 2", lat); end
        run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'h7711) begin errors++; $display("FAIL be00_data: got %h expected 7711", rd); end
    endtask

    task automatic test_abort();
        int lat, ep; logic [15:0] rd, prd; logic pr;
        int nresp = 0;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 16'h0010;
        @(posedge clk); #1;
        mem_read = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mem_resp) nresp++;
        end
        checks++; if (nresp !== 0) begin errors++; $display("FAIL abort_resp: got %0d pulses expected 0", nresp); end
        run_txn(1'b0, 1'b1, 16'h0050, 16'hBEEF, 2'b11, lat, rd, ep, pr, prd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_abort_lat: got %0d expected 2", lat); end
        run_txn(1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL post_abort_data: got %h expected beef", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat, ep; logic [15:0] rd, prd; logic pr;
        int nresp = 0;
        run_txn(1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, lat, rd, ep, pr, prd);
        @(posedge clk); #1;
        mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'hFFFF; mem_byte_enable = 2'b11;
        @(negedge clk); if (mem_resp) nresp++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); if (mem_resp) nresp++;
        @(posedge clk); #1;
        reset = 1'b0; mem_write = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_resp) nresp++;
        end
        checks++; if (nresp !== 0) begin errors++; $display("FAIL rst_mid_resp: got %0d pulses expected 0", nresp); end
        run_txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL rst_mid_data: got %h expected 1111", rd); end
    endtask

    task automatic test_alias_err();
        int lat, ep; logic [15:0] rd, prd; logic pr;
        run_txn(1'b0, 1'b1, 16'h0202, 16'hC0DE, 2'b11, lat, rd, ep, pr, prd);
        run_txn(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'hC0DE) begin errors++; $display("FAIL alias_0002: got %h expected c0de", rd); end
        run_txn(1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'hC0DE) begin errors++; $display("FAIL alias_0003: got %h expected c0de", rd); end
        run_txn(1'b1, 1'b0, 16'hFE02, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'hC0DE) begin errors++; $display("FAIL alias_fe02: got %h expected c0de", rd); end
        run_txn(1'b1, 1'b1, 16'h0060, 16'h5A5A, 2'b11, lat, rd, ep, pr, prd);
        checks++; if (ep !== 1) begin errors++; $display("FAIL err_pulses: got %0d expected 1", ep); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL err_lat: got %0d expected 2", lat); end
        run_txn(1'b1, 1'b0, 16'h0060, 16'h0000, 2'b00, lat, rd, ep, pr, prd);
        checks++; if (rd !== 16'h5A5A) begin errors++; $display("FAIL err_write_data: got %h expected 5a5a", rd); end
    endtask

    task automatic test_back_to_back();
        logic        exp_resp;
        logic [15:0] exp_data;
        @(posedge clk); #1;
        b_write = 1'b1; b_address = 16'h0004; b_wdata = 16'h9ABC; b_be = 2'b11;
        @(negedge clk);
        checks++; if (b_resp !== 1'b0) begin errors++; $display("FAIL l1_wr_early: got %b expected 0", b_resp); end
        @(negedge clk);
        checks++; if (b_resp !== 1'b1) begin errors++; $display("FAIL l1_wr_resp: got %b expected 1", b_resp); end
        @(posedge clk); #1;
        b_write = 1'b0;
        @(posedge clk); #1;
        b_read = 1'b1; b_address = 16'h0004;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_resp = (c % 2 == 1) ? 1'b1 : 1'b0;
            exp_data = (c % 2 == 1) ? 16'h9ABC : 16'h0000;
            checks++; if (b_resp !== exp_resp) begin errors++; $display("FAIL b2b_resp[%0d]: got %b expected %b", c, b_resp, exp_resp); end
            checks++; if (b_rdata !== exp_data) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", c, b_rdata, exp_data); end
        end
        @(posedge clk); #1;
        b_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0000; mem_wdata = 16'h0000; mem_byte_enable = 2'b00;
        b_read = 1'b0; b_write = 1'b0; b_address = 16'h0000; b_wdata = 16'h0000; b_be = 2'b00;
        repeat (3) @(posedge clk);
        test_reset();
        test_req_through_reset();
        test_write_read();
        test_byte_write();
        test_abort();
        test_reset_mid_write();
        test_alias_err();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
